// File: rtl/mmix_defs.sv
// Shared MMIX memory-port definitions: access-size encoding, bridge state enum and
// the address alignment helper used by the bus bridge.
package mmix_defs;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_WYDE  = 2'd1,
      SZ_TETRA = 2'd2,
      SZ_OCTA  = 2'd3
   } mmix_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CMD    = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_DONE   = 2'd3
   } bridge_state_e;

   // Clears the low log2(size) address bits so every access is naturally aligned.
   function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
      return a & ~((32'd1 << sz) - 32'd1);
   endfunction

endpackage

// File: rtl/mmb_lane_map.sv
// Combinational lane mapper: places store data on big-endian 32-bit bus lanes with
// byteenables and the beat address, and extracts right-justified load data from a bus word.
module mmb_lane_map
   import mmix_defs::*;
(
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic        i_beat,
   input  logic [63:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_be,
   output logic [31:0] o_bus_wdata,
   output logic [31:0] o_rdata
);

   always_comb begin
      o_bus_addr  = {i_addr[31:2], 2'b00};
      o_be        = 4'b1111;
      o_bus_wdata = i_wdata[31:0];
      o_rdata     = i_rword;
      case (mmix_size_e'(i_size))
         SZ_BYTE: begin
            // Byte offset 0 lives in bits [31:24], so the lane index counts down with the offset.
            o_be        = 4'b1000 >> i_addr[1:0];
            o_bus_wdata = {4{i_wdata[7:0]}};
            o_rdata     = {24'd0, i_rword[{~i_addr[1:0], 3'b000} +: 8]};
         end
         SZ_WYDE: begin
            o_be        = i_addr[1] ? 4'b0011 : 4'b1100;
            o_bus_wdata = {2{i_wdata[15:0]}};
            o_rdata     = {16'd0, (i_addr[1] ? i_rword[15:0] : i_rword[31:16])};
         end
         SZ_TETRA: begin
            o_be = 4'b1111;
         end
         SZ_OCTA: begin
            o_bus_addr  = {i_addr[31:3], i_beat, 2'b00};
            o_bus_wdata = i_beat ? i_wdata[31:0] : i_wdata[63:32];
         end
         default: begin
            o_be = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges the MMIX load/store port onto a 32-bit Avalon-MM master; octas take two beats.
// Defining MEM_BRIDGE_TIMEOUT_EN adds a per-beat timeout that aborts with mem_error.
module mem_bus_bridge
   import mmix_defs::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [63:0] mem_address,
   input  logic [1:0]  mem_datasize,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [63:0] mem_writedata,
   output logic [63:0] mem_readdata,
   output logic        mem_done,
   output logic        mem_error,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid
);

   bridge_state_e r_state;
   logic          r_beat;
   logic          r_is_wr;
   logic          r_done;
   logic          r_read;
   logic          r_write;
   logic [1:0]    r_size;
   logic [31:0]   r_addr;
   logic [63:0]   r_wdata;
   logic [63:0]   r_rdata;
   logic [31:0]   r_avm_addr;
   logic [3:0]    r_avm_be;
   logic [31:0]   r_avm_wdata;

   logic          w_idle;
   logic          w_req;
   logic          w_octa;
   logic          w_last;
   logic [1:0]    w_lm_size;
   logic [31:0]   w_lm_addr;
   logic [63:0]   w_lm_wdata;
   logic [31:0]   w_bus_addr;
   logic [3:0]    w_be;
   logic [31:0]   w_bus_wdata;
   logic [31:0]   w_rdata;
   logic          w_unused_hi;

   assign w_unused_hi = ^mem_address[63:32];

   assign w_idle = (r_state == ST_IDLE);
   assign w_req  = mem_read | mem_write;
   assign w_octa = (r_size == SZ_OCTA);
   assign w_last = !w_octa || r_beat;

   // In IDLE the mapper prepares beat 0 from the live request; afterwards it prepares beat 1.
   assign w_lm_size  = w_idle ? mem_datasize : r_size;
   assign w_lm_addr  = w_idle ? align_addr(mem_address[31:0], mem_datasize) : r_addr;
   assign w_lm_wdata = w_idle ? mem_writedata : r_wdata;

   mmb_lane_map u_lane_map (
      .i_size      (w_lm_size),
      .i_addr      (w_lm_addr),
      .i_beat      (~w_idle),
      .i_wdata     (w_lm_wdata),
      .i_rword     (avm_readdata),
      .o_bus_addr  (w_bus_addr),
      .o_be        (w_be),
      .o_bus_wdata (w_bus_wdata),
      .o_rdata     (w_rdata)
   );

`ifdef MEM_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_tmo_cnt;
   logic          r_err;
   logic          w_tmo;
   logic          w_stall;
   logic          w_beat_start;

   assign w_tmo        = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_stall      = ((r_state == ST_CMD) && avm_waitrequest) ||
                         ((r_state == ST_RDWAIT) && !avm_readdatavalid);
   assign w_beat_start = (w_idle && w_req) ||
                         ((r_state == ST_CMD) && !avm_waitrequest && r_is_wr && !w_last) ||
                         ((r_state == ST_RDWAIT) && avm_readdatavalid && !w_last);
   assign mem_error    = r_err;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
   assign mem_error    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_beat      <= 1'b0;
         r_is_wr     <= 1'b0;
         r_done      <= 1'b0;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_size      <= 2'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_avm_addr  <= '0;
         r_avm_be    <= '0;
         r_avm_wdata <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
         r_tmo_cnt   <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
         r_err <= 1'b0;
         if (r_state == ST_CMD || r_state == ST_RDWAIT)
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         if (w_beat_start)
            r_tmo_cnt <= '0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_is_wr     <= mem_write;
                  r_size      <= mem_datasize;
                  r_addr      <= w_lm_addr;
                  r_wdata     <= mem_writedata;
                  r_beat      <= 1'b0;
                  r_avm_addr  <= w_bus_addr;
                  r_avm_be    <= w_be;
                  r_avm_wdata <= w_bus_wdata;
                  r_write     <= mem_write;
                  r_read      <= ~mem_write;
                  r_state     <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (!avm_waitrequest) begin
                  if (!r_is_wr) begin
                     r_read  <= 1'b0;
                     r_state <= ST_RDWAIT;
                  end else if (w_last) begin
                     r_write <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     // Second octa write beat follows back-to-back with the strobe still up.
                     r_beat      <= 1'b1;
                     r_avm_addr  <= w_bus_addr;
                     r_avm_be    <= w_be;
                     r_avm_wdata <= w_bus_wdata;
                  end
               end
            end
            ST_RDWAIT: begin
               if (avm_readdatavalid) begin
                  if (!w_octa)
                     r_rdata <= {32'd0, w_rdata};
                  else if (r_beat)
                     r_rdata[31:0] <= w_rdata;
                  else
                     r_rdata[63:32] <= w_rdata;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_beat     <= 1'b1;
                     r_avm_addr <= w_bus_addr;
                     r_avm_be   <= w_be;
                     r_read     <= 1'b1;
                     r_state    <= ST_CMD;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
`ifdef MEM_BRIDGE_TIMEOUT_EN
         if (w_stall && w_tmo) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            if (!r_is_wr)
               r_rdata <= '1;
            r_state <= ST_DONE;
         end
`endif
      end
   end

   assign mem_readdata   = r_rdata;
   assign mem_done       = r_done;
   assign avm_address    = r_avm_addr;
   assign avm_byteenable = r_avm_be;
   assign avm_read       = r_read;
   assign avm_write      = r_write;
   assign avm_writedata  = r_avm_wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: random MMIX accesses against a byte-array memory model,
// an Avalon slave model with random waits/latency, plus directed corner cases.
`timescale 1ns/1ps
module tb_mem_bus_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1023;
`endif

   logic        clk;
   logic        reset_n;
   logic [63:0] mem_address;
   logic [1:0]  mem_datasize;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_writedata;
   logic [63:0] mem_readdata;
   logic        mem_done;
   logic        mem_error;
   logic [31:0] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;

   mem_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .mem_address       (mem_address),
      .mem_datasize      (mem_datasize),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_readdata      (mem_readdata),
      .mem_done          (mem_done),
      .mem_error         (mem_error),
      .avm_address       (avm_address),
      .avm_byteenable    (avm_byteenable),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_pass;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Slave memory (16 big-endian words) and the byte-level reference view of it.
   logic [31:0] mem_w [0:15];
   logic [7:0]  ref_b [0:63];

   bit          zero_wait;
   bit          hold_rd;
   bit          inject_rdv;
   int          force_wait;
   int          cmd_cyc;
   bit          rd_pend;
   int          rd_cnt;
   logic [31:0] rd_word;
   int          wait_run;
   bit          prev_hold;
   logic [69:0] prev_cmd;
   logic [31:0] log_addr [$];
   logic [3:0]  log_be [$];
   logic [31:0] log_wd [$];

   // Avalon slave: decisions made on the falling edge, sampled by the DUT on the rising edge.
   initial begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      rd_pend   = 1'b0;
      rd_cnt    = 0;
      rd_word   = '0;
      wait_run  = 0;
      prev_hold = 1'b0;
      prev_cmd  = '0;
      cmd_cyc   = 0;
      forever begin
         @(negedge clk);
         avm_readdatavalid = 1'b0;
         if (!reset_n) begin
            rd_pend         = 1'b0;
            prev_hold       = 1'b0;
            wait_run        = 0;
            avm_waitrequest = 1'b0;
         end else begin
            if (rd_pend) begin
               if (rd_cnt <= 1) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = rd_word;
                  rd_pend           = 1'b0;
               end else begin
                  rd_cnt--;
               end
            end
            if (inject_rdv) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = 32'hDEADBEEF;
            end
            if (prev_hold)
               chk("stable", {58'd0, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata},
                   {58'd0, prev_cmd});
            if (avm_read || avm_write) begin
               cmd_cyc++;
               if (force_wait > 0) begin
                  avm_waitrequest = 1'b1;
                  force_wait--;
               end else if (zero_wait) begin
                  avm_waitrequest = 1'b0;
               end else begin
                  avm_waitrequest = (wait_run < 2) && ($urandom % 3 == 0);
               end
               wait_run = avm_waitrequest ? wait_run + 1 : 0;
               if (!avm_waitrequest) begin
                  chk("outstanding", {127'd0, rd_pend}, 128'd0);
                  chk("word_align", {126'd0, avm_address[1:0]}, 128'd0);
                  log_addr.push_back(avm_address);
                  log_be.push_back(avm_byteenable);
                  log_wd.push_back(avm_writedata);
                  if (avm_write) begin
                     for (int b = 0; b < 4; b++)
                        if (avm_byteenable[b])
                           mem_w[avm_address[5:2]][8*b +: 8] = avm_writedata[8*b +: 8];
                  end else if (!hold_rd) begin
                     rd_pend = 1'b1;
                     rd_cnt  = zero_wait ? 1 : 1 + int'($urandom % 3);
                     rd_word = mem_w[avm_address[5:2]];
                  end
               end
            end else begin
               avm_waitrequest = $urandom % 2 == 1;
               wait_run        = 0;
            end
            prev_hold = (avm_read || avm_write) && avm_waitrequest;
            prev_cmd  = {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata};
         end
      end
   end

   task automatic do_req(input bit wr, input logic [1:0] sz, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output int lat,
                         output bit err);
      @(negedge clk);
      mem_address   = a;
      mem_datasize  = sz;
      mem_writedata = wd;
      mem_write     = wr;
      mem_read      = !wr;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!mem_done && lat < 200);
      chk("done_seen", {127'd0, mem_done}, 128'd1);
      rd  = mem_readdata;
      err = mem_error;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      chk("done_pulse", {127'd0, mem_done}, 128'd0);
   endtask

   function automatic logic [63:0] ref_read(input logic [1:0] sz, input logic [5:0] a6);
      int n  = 1 << sz;
      int al = int'(a6) & ~(n - 1);
      logic [63:0] e = '0;
      for (int i = 0; i < n; i++) e = {e[55:0], ref_b[al + i]};
      return e;
   endfunction

   task automatic ref_write(input logic [1:0] sz, input logic [5:0] a6, input logic [63:0] wd);
      int n  = 1 << sz;
      int al = int'(a6) & ~(n - 1);
      for (int i = 0; i < n; i++) ref_b[al + i] = wd[8*(n-1-i) +: 8];
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_be.delete();
      log_wd.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic [63:0] a;
      logic [63:0] wd;
      logic [63:0] exp;
      logic [5:0]  a6;
      logic [1:0]  sz;
      bit          wr;
      bit          err;
      int          lat;
      int          dones;

      n_chk = 0;
      n_pass = 0;
      reset_n       = 1'b0;
      mem_address   = '0;
      mem_datasize  = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_writedata = '0;
      zero_wait  = 1'b0;
      hold_rd    = 1'b0;
      inject_rdv = 1'b0;
      force_wait = 0;
      for (int i = 0; i < 16; i++) mem_w[i] = $urandom;
      for (int i = 0; i < 64; i++) ref_b[i] = mem_w[i / 4][31 - 8*(i % 4) -: 8];

      repeat (3) @(negedge clk);
      chk("rst_done", {127'd0, mem_done}, 128'd0);
      chk("rst_error", {127'd0, mem_error}, 128'd0);
      chk("rst_strobes", {126'd0, avm_read, avm_write}, 128'd0);
      chk("rst_addr", {96'd0, avm_address}, 128'd0);
      chk("rst_be", {124'd0, avm_byteenable}, 128'd0);
      chk("rst_wdata", {96'd0, avm_writedata}, 128'd0);
      chk("rst_rdata", {64'd0, mem_readdata}, 128'd0);
      reset_n = 1'b1;

      // Random accesses against the byte-array model.
      for (int t = 0; t < 160; t++) begin
         wr = ($urandom % 2) == 1;
         sz = 2'($urandom % 4);
         a6 = 6'($urandom % 64);
         a  = {$urandom, 26'h0000014, a6};
         wd = {$urandom, $urandom};
         do_req(wr, sz, a, wd, rd, lat, err);
         chk("no_error", {127'd0, err}, 128'd0);
         if (wr) ref_write(sz, a6, wd);
         else chk("rand_read", {64'd0, rd}, {64'd0, ref_read(sz, a6)});
      end

      // Zero-wait latency.
      zero_wait = 1'b1;
      do_req(1'b1, 2'd2, 64'h5010, 64'hCAFEF00D, rd, lat, err);
      ref_write(2'd2, 6'h10, 64'hCAFEF00D);
      chk("lat_tetra_wr", lat, 2);
      do_req(1'b0, 2'd2, 64'h5010, 64'h0, rd, lat, err);
      chk("lat_tetra_rd", lat, 3);
      chk("lat_tetra_rd_data", {64'd0, rd}, {96'd0, 32'hCAFEF00D});
      exp = ref_read(2'd3, 6'h18);
      do_req(1'b0, 2'd3, 64'h5018, 64'h0, rd, lat, err);
      chk("lat_octa_rd", lat, 5);
      chk("lat_octa_rd_data", {64'd0, rd}, {64'd0, exp});

      // Tetra write at a misaligned address.
      clear_log();
      do_req(1'b1, 2'd2, 64'h1006, 64'h11223344, rd, lat, err);
      chk("tw_beats", log_addr.size(), 1);
      chk("tw_addr", {96'd0, log_addr[0]}, {96'd0, 32'h1004});
      chk("tw_be", {124'd0, log_be[0]}, {124'd0, 4'b1111});
      chk("tw_wdata", {96'd0, log_wd[0]}, {96'd0, 32'h11223344});

      // Byte read from lane 2.
      clear_log();
      mem_w[0] = 32'hAABBCCDD;
      do_req(1'b0, 2'd0, 64'h2001, 64'h0, rd, lat, err);
      chk("br_be", {124'd0, log_be[0]}, {124'd0, 4'b0100});
      chk("br_data", {64'd0, rd}, {64'd0, 64'h00000000000000BB});

      // Octa read split into two beats.
      clear_log();
      mem_w[2] = 32'h01234567;
      mem_w[3] = 32'h89ABCDEF;
      do_req(1'b0, 2'd3, 64'h300C, 64'h0, rd, lat, err);
      chk("or_beats", log_addr.size(), 2);
      chk("or_addr0", {96'd0, log_addr[0]}, {96'd0, 32'h3008});
      chk("or_addr1", {96'd0, log_addr[1]}, {96'd0, 32'h300C});
      chk("or_data", {64'd0, rd}, {64'd0, 64'h0123456789ABCDEF});

      // Wyde write stalled for three cycles.
      clear_log();
      cmd_cyc    = 0;
      force_wait = 3;
      do_req(1'b1, 2'd1, 64'h4002, 64'hBEEF, rd, lat, err);
      chk("ww_cmd_cycles", cmd_cyc, 4);
      chk("ww_beats", log_addr.size(), 1);
      chk("ww_be", {124'd0, log_be[0]}, {124'd0, 4'b0011});
      chk("ww_wdata", {96'd0, log_wd[0]}, {96'd0, 32'hBEEFBEEF});
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (mem_done) dones++;
      end
      chk("ww_single_done", dones, 0);

      // Reset while waiting for read data.
      clear_log();
      hold_rd = 1'b1;
      @(negedge clk);
      mem_address  = 64'h5000;
      mem_datasize = 2'd2;
      mem_read     = 1'b1;
      for (int k = 0; k < 20 && log_addr.size() == 0; k++) begin
         @(posedge clk);
         #1;
      end
      chk("rst_mid_accepted", log_addr.size(), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_strobes", {126'd0, avm_read, avm_write}, 128'd0);
      chk("rst_mid_done", {126'd0, mem_done, mem_error}, 128'd0);
      chk("rst_mid_addr", {96'd0, avm_address}, 128'd0);
      chk("rst_mid_be_wd", {92'd0, avm_byteenable, avm_writedata}, 128'd0);
      chk("rst_mid_rdata", {64'd0, mem_readdata}, 128'd0);
      mem_read = 1'b0;
      hold_rd  = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      inject_rdv = 1'b1;
      @(posedge clk);
      inject_rdv = 1'b0;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_done) dones++;
      end
      chk("late_rdv_ignored", dones, 0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
      // Read whose data never arrives.
      hold_rd = 1'b1;
      do_req(1'b0, 2'd2, 64'h5000, 64'h0, rd, lat, err);
      chk("tmo_error", {127'd0, err}, 128'd1);
      chk("tmo_rdata", {64'd0, rd}, {64'd0, {64{1'b1}}});
      chk("tmo_lat", lat, 9);
      chk("tmo_strobe", {127'd0, avm_read}, 128'd0);
      hold_rd = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
